// File: rtl/seq_rbs_sub.sv
// -----------------------------------------------------------------------------
// seq_rbs_sub: sequential ripple-borrow subtractor.
//
// Computes diff = (a - b - bin) mod 2^WIDTH and bout = (a < b + bin), one
// CHUNK-bit slice per clock, LSB slice first, with the borrow carried between
// slices in a register. This keeps the combinational path to one CHUNK-bit
// borrow chain plus the slice mux.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only when not busy
//   a      in   WIDTH  minuend, captured on the accepting edge
//   b      in   WIDTH  subtrahend, captured on the accepting edge
//   bin    in   1      borrow-in, captured on the accepting edge
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse, diff/bout final
//   diff   out  WIDTH  result (partially updated while busy)
//   bout   out  1      borrow-out, updated only on the final slice
// -----------------------------------------------------------------------------
module seq_rbs_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int N  = WIDTH / CHUNK;
  // One extra bit so the index never needs to wrap.
  localparam int KW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] diff_q;
  logic             brw_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;
  logic [KW-1:0]    k_q;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK-1:0] diff_chunk_d;
  logic             borrow_d;
  logic             last_chunk;
  logic             accept;

  assign accept = start && (state_q != RUN);

  // Slice select and one CHUNK-bit subtract with borrow.
  always_comb begin
    // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    // CHUNK+1-bit difference: the top bit is 1 exactly when the slice underflows.
    {borrow_d, diff_chunk_d} = {1'b0, a_chunk} - {1'b0, b_chunk} - (CHUNK+1)'(brw_q);
    last_chunk = (k_q == KW'(N - 1));
  end

  // NOTE: operand copies are pure datapath, only read while RUN after a
  // capture, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      brw_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            brw_q   <= bin;
            k_q     <= '0;
          end else begin
            state_q <= IDLE;
          end
        end

        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
              diff_q[i*CHUNK +: CHUNK] <= diff_chunk_d;
            end
          end
          brw_q <= borrow_d;
          k_q   <= k_q + KW'(1);
          if (last_chunk) begin
            bout_q  <= borrow_d;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_seq_rbs_sub.sv
// -----------------------------------------------------------------------------
// tb_seq_rbs_sub: self-checking bench for seq_rbs_sub.
//
// Two instances share one stimulus: u_dut0 with the default 32/8 slicing
// (4 compute cycles) and u_dut1 with CHUNK=WIDTH=32 (1 compute cycle).
// A transaction-level model per instance predicts busy/done and the final
// a-b-bin result; a compare process checks every cycle. Directed sequences add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_seq_rbs_sub;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        bin;

  logic        busy0, done0, bout0;
  logic [31:0] diff0;
  logic        busy1, done1, bout1;
  logic [31:0] diff1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  seq_rbs_sub #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy0), .done(done0), .diff(diff0), .bout(bout0)
  );

  seq_rbs_sub #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model: an accepted request occupies the block for
  // n_cyc[j] cycles, after which the full-width a-b-bin result (33 bits, top
  // bit = borrow) becomes visible together with a one-cycle done.
  // ---------------------------------------------------------------------------
  int          n_cyc [2] = '{4, 1};
  int          m_rem [2];
  bit          m_done[2];
  logic [31:0] m_diff[2];
  logic        m_bout[2];
  logic [32:0] m_pend[2];
  int          m_acc [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 2; j++) begin
        m_rem[j]  <= 0;
        m_done[j] <= 1'b0;
        m_diff[j] <= '0;
        m_bout[j] <= 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        m_done[j] <= 1'b0;
        if (m_rem[j] != 0) begin
          m_rem[j] <= m_rem[j] - 1;
          if (m_rem[j] == 1) begin
            m_done[j] <= 1'b1;
            m_diff[j] <= m_pend[j][31:0];
            m_bout[j] <= m_pend[j][32];
          end
        end else if (start) begin
          m_rem[j]  <= n_cyc[j];
          m_pend[j] <= {1'b0, a} - {1'b0, b} - {32'b0, bin};
          m_acc[j]  <= m_acc[j] + 1;
        end
      end
    end
  end

  // Compare process: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dut0_busy", {32'b0, busy0}, {32'b0, m_rem[0] != 0});
      check("dut0_done", {32'b0, done0}, {32'b0, m_done[0]});
      if (m_rem[0] == 0) begin
        check("dut0_diff", {1'b0, diff0}, {1'b0, m_diff[0]});
        check("dut0_bout", {32'b0, bout0}, {32'b0, m_bout[0]});
      end
      check("dut1_busy", {32'b0, busy1}, {32'b0, m_rem[1] != 0});
      check("dut1_done", {32'b0, done1}, {32'b0, m_done[1]});
      if (m_rem[1] == 0) begin
        check("dut1_diff", {1'b0, diff1}, {1'b0, m_diff[1]});
        check("dut1_bout", {32'b0, bout1}, {32'b0, m_bout[1]});
      end
    end
  end

  // One operation on the default instance with literal expectations.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin,
                        input logic [31:0] ediff, input logic ebout, input string name);
    int cyc = 0;
    int busy_cnt = 0;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; bin = tbin;
    @(negedge clk);
    // Operand changes after acceptance must not disturb the running operation.
    start = 1'b0; a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
    while (!done0 && cyc < 20) begin
      if (busy0) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({name, "_done_seen"}, {32'b0, done0}, 33'd1);
    check({name, "_busy_len"}, 33'(busy_cnt), 33'd4);
    check({name, "_diff"}, {1'b0, diff0}, {1'b0, ediff});
    check({name, "_bout"}, {32'b0, bout0}, {32'b0, ebout});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'(1);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cnt;
    int cyc;
    int prev;
    int ndone;
    logic [31:0] got;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_busy", {32'b0, busy0}, 33'd0);
    check("rst_done", {32'b0, done0}, 33'd0);
    check("rst_diff", {1'b0, diff0}, 33'd0);
    check("rst_bout", {32'b0, bout0}, 33'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Directed arithmetic with literal results.
    run_op(32'd100,        32'd37,        1'b0, 32'd63,        1'b0, "basic");
    run_op(32'd5,          32'd9,         1'b0, 32'hFFFF_FFFC, 1'b1, "underflow");
    run_op(32'd0,          32'd0,         1'b1, 32'hFFFF_FFFF, 1'b1, "zero_bin");
    run_op(32'h0001_0000,  32'd1,         1'b0, 32'h0000_FFFF, 1'b0, "xchunk");
    run_op(32'h8000_0000,  32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, "msb");

    // Start while busy: the second request lands on E2 and must be ignored.
    @(negedge clk);
    start = 1'b1; a = 32'd1000; b = 32'd1; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; got = '0;
    repeat (12) begin
      if (done0) begin
        cnt++;
        got = diff0;
      end
      @(negedge clk);
    end
    check("busy_start_ndone", 33'(cnt), 33'd1);
    check("busy_start_diff", {1'b0, got}, 33'd999);

    // Reset in the middle of RUN, after E2.
    @(negedge clk);
    start = 1'b1; a = 32'h1234_5678; b = 32'h0000_0001; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {32'b0, busy0}, 33'd0);
    check("midrst_done", {32'b0, done0}, 33'd0);
    check("midrst_diff", {1'b0, diff0}, 33'd0);
    check("midrst_bout", {32'b0, bout0}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0) cnt++;
    end
    check("midrst_no_done", 33'(cnt), 33'd0);
    run_op(32'h1234_5678, 32'h0000_0001, 1'b0, 32'h1234_5677, 1'b0, "after_rst");

    // Back-to-back: start held high, fresh operands on each done cycle.
    @(negedge clk);
    start = 1'b1; a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
    prev = -1; ndone = 0; cyc = 0;
    while (ndone < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done0) begin
        if (prev >= 0) check("b2b_spacing", 33'(cyc - prev), 33'd5);
        prev = cyc;
        ndone++;
        a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    check("b2b_count", 33'(ndone), 33'd6);
    repeat (6) @(negedge clk);

    // Random traffic until the single-slice instance has taken 1000 requests.
    cyc = 0;
    while (cyc < 6000 && m_acc[1] < 1000) begin
      @(negedge clk);
      cyc++;
      start = ($urandom_range(0, 3) != 0);
      a = pick(); b = pick(); bin = 1'($urandom_range(0, 1));
    end
    check("rand_vectors", {32'b0, m_acc[1] >= 1000}, 33'd1);
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
